// File: rtl/attention_score_unit.sv
// ============================================================================
// Module      : attention_score_unit
// Description : Key cache plus scaled dot-product scorer. Projected K vectors
//               are stored one per token. A projected Q vector is scored
//               against every cached key, oldest first:
//                   score_j = (q . k_j) >>> SCALE_SHIFT
//               One signed product is accumulated per cycle. Scores stream
//               out one per key to the softmax stage.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature (compile-time macro SCORE_MAX_EN):
//   When defined, adds output max_score. It holds the maximum scaled score of
//   the last scan and is valid while done=1. It resets to 0.
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   clear        in   empty key cache, abort any scan (no done pulse)
//   k_wr_en      in   write k_vector_in into the cache (IDLE, not full)
//   k_vector_in  in   packed K, element i at [i*ACCUM_WIDTH +: ACCUM_WIDTH]
//   q_start      in   start a scan with q_vector_in (IDLE only)
//   q_vector_in  in   packed Q, same packing, sampled with q_start
//   score_valid  out  score_out/score_idx/score_last valid this cycle
//   score_out    out  signed scaled score
//   score_idx    out  cache index of the scored key
//   score_last   out  final score of the scan
//   busy         out  scan in progress
//   done         out  one-cycle pulse at scan completion
//   k_count      out  number of cached keys
//   k_full       out  k_count == SEQ_LEN
//   max_score    out  (SCORE_MAX_EN only) max scaled score of the scan
// ============================================================================
`default_nettype none

module attention_score_unit #(
  parameter int ACCUM_WIDTH = 16,
  parameter int D_K         = 2,
  parameter int SEQ_LEN     = 4,
  parameter int SCORE_WIDTH = 32,
  parameter int SCALE_SHIFT = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              k_wr_en,
  input  logic [D_K*ACCUM_WIDTH-1:0]        k_vector_in,
  input  logic                              q_start,
  input  logic [D_K*ACCUM_WIDTH-1:0]        q_vector_in,
  output logic                              score_valid,
  output logic signed [SCORE_WIDTH-1:0]     score_out,
  output logic [$clog2(SEQ_LEN)-1:0]        score_idx,
  output logic                              score_last,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(SEQ_LEN+1)-1:0]      k_count,
  output logic                              k_full
`ifdef SCORE_MAX_EN
  ,
  output logic signed [SCORE_WIDTH-1:0]     max_score
`endif
);

  localparam int IDX_W  = $clog2(SEQ_LEN);
  localparam int CNT_W  = $clog2(SEQ_LEN + 1);
  localparam int ELEM_W = (D_K > 1) ? $clog2(D_K) : 1;
  localparam int PROD_W = 2 * ACCUM_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Key cache; contents are don't-care after reset, so it carries no reset.
  logic [D_K*ACCUM_WIDTH-1:0]      r_cache [SEQ_LEN];

  logic [D_K*ACCUM_WIDTH-1:0]      r_q;
  logic [ELEM_W-1:0]               r_elem;
  logic [IDX_W-1:0]                r_key_idx;
  logic signed [SCORE_WIDTH-1:0]   r_acc;

  logic [D_K*ACCUM_WIDTH-1:0]      w_key_vec;
  logic signed [ACCUM_WIDTH-1:0]   w_q_arr [D_K];
  logic signed [ACCUM_WIDTH-1:0]   w_k_arr [D_K];
  logic signed [PROD_W-1:0]        w_prod;
  logic signed [SCORE_WIDTH-1:0]   w_acc_base;
  logic signed [SCORE_WIDTH-1:0]   w_acc_sum;
  logic signed [SCORE_WIDTH-1:0]   w_score;
  logic                            w_wr_accept;
  logic [CNT_W-1:0]                w_count_next;
  logic                            w_elem_last;
  logic                            w_key_last;

`ifdef SCORE_MAX_EN
  logic signed [SCORE_WIDTH-1:0]   r_max;
`endif

  // --------------------------------------------------------------------------
  // Element unpacking of the latched Q and of the key being scored
  // --------------------------------------------------------------------------
  assign w_key_vec = r_cache[r_key_idx];

  generate
    for (genvar gi = 0; gi < D_K; gi++) begin : g_unpack
      assign w_q_arr[gi] = r_q[gi*ACCUM_WIDTH +: ACCUM_WIDTH];
      assign w_k_arr[gi] = w_key_vec[gi*ACCUM_WIDTH +: ACCUM_WIDTH];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // MAC datapath. The first element of each key restarts the sum from zero,
  // so the accumulator never needs an explicit clear between keys.
  // The size cast sign-extends the product; the sum wraps modulo 2^SCORE_WIDTH.
  // --------------------------------------------------------------------------
  assign w_prod     = w_q_arr[r_elem] * w_k_arr[r_elem];
  assign w_acc_base = (r_elem == '0) ? '0 : r_acc;
  assign w_acc_sum  = w_acc_base + SCORE_WIDTH'(w_prod);
  assign w_score    = w_acc_sum >>> SCALE_SHIFT;

  assign w_elem_last = (r_elem == ELEM_W'(D_K - 1));
  // k_count cannot change during a scan, so it bounds the key index directly.
  assign w_key_last  = ((CNT_W'(r_key_idx) + CNT_W'(1)) == k_count);

  // A write is accepted before a same-cycle q_start, so the scan length uses
  // the post-write count.
  assign w_wr_accept  = (r_state == S_IDLE) && k_wr_en && !k_full;
  assign w_count_next = k_count + CNT_W'(w_wr_accept);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (q_start) begin
            w_state_next = (w_count_next == '0) ? S_DONE : S_MAC;
          end
        end
        S_MAC: begin
          if (w_elem_last) begin
            w_state_next = S_EMIT;
          end
        end
        S_EMIT: begin
          w_state_next = w_key_last ? S_DONE : S_MAC;
        end
        S_DONE: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Key cache write
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && !clear && w_wr_accept) begin
      r_cache[k_count[IDX_W-1:0]] <= k_vector_in;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_q         <= '0;
      r_elem      <= '0;
      r_key_idx   <= '0;
      r_acc       <= '0;
      k_count     <= '0;
      k_full      <= 1'b0;
      score_valid <= 1'b0;
      score_out   <= '0;
      score_idx   <= '0;
      score_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef SCORE_MAX_EN
      r_max       <= '0;
      max_score   <= '0;
`endif
    end else begin
      if (w_wr_accept) begin
        k_count <= w_count_next;
        k_full  <= (w_count_next == CNT_W'(SEQ_LEN));
      end

      score_valid <= 1'b0;
      busy        <= (w_state_next == S_MAC) || (w_state_next == S_EMIT);
      done        <= (w_state_next == S_DONE);

      case (r_state)
        S_IDLE: begin
          if (q_start) begin
            r_q       <= q_vector_in;
            r_elem    <= '0;
            r_key_idx <= '0;
`ifdef SCORE_MAX_EN
            r_max     <= '0;
`endif
          end
        end
        S_MAC: begin
          r_acc <= w_acc_sum;
          if (w_elem_last) begin
            r_elem      <= '0;
            score_valid <= 1'b1;
            score_out   <= w_score;
            score_idx   <= r_key_idx;
            score_last  <= w_key_last;
`ifdef SCORE_MAX_EN
            if ((r_key_idx == '0) || (w_score > r_max)) begin
              r_max <= w_score;
            end
`endif
          end else begin
            r_elem <= r_elem + ELEM_W'(1);
          end
        end
        S_EMIT: begin
          r_key_idx <= r_key_idx + IDX_W'(1);
        end
        default: begin
        end
      endcase

`ifdef SCORE_MAX_EN
      // An empty scan has no scores; report 0 for it.
      if (w_state_next == S_DONE) begin
        max_score <= (r_state == S_EMIT) ? r_max : '0;
      end
`endif
    end
  end

endmodule

`default_nettype wire
